ram_arbiter: RTL and testbench
==============================

Name: ram_arbiter

Overview:
- Two-requester round-robin arbiter and sequencer for the team's 64x8 single-port synchronous RAM (write on posedge when WE; read address registered, Q valid the cycle after address issue).
- Sits between two client masters (A, B) and one RAM instance.
- Issues at most one access per cycle to the RAM and returns read data to the correct requester.

Parameters:
- AW, 6, RAM address width (64 words).
- DW, 8, RAM data width.

Ports:
- CLK  input  1  system clock, all state on rising edge.
- RST_N  input  1  asynchronous active-low reset.
- REQ_A / REQ_B  input  1  access request, held until granted.
- WE_A / WE_B  input  1  1 = write, 0 = read; qualified by REQ.
- ADDR_A / ADDR_B  input  AW  access address.
- DATA_A / DATA_B  input  DW  write data.
- GNT_A / GNT_B  output  1  combinational grant; request accepted this cycle.
- RVALID_A / RVALID_B  output  1  read data valid (registered).
- RDATA_A / RDATA_B  output  DW  read data, RAM_Q when own RVALID, else 0.
- RAM_ADDR  output  AW  to RAM ADDR.
- RAM_DATA  output  DW  to RAM DATA.
- RAM_WE  output  1  to RAM WE.
- RAM_Q  input  DW  from RAM Q.

Behaviour:
- Reset asserted (async): LAST register = B, so A wins first tie. RVALID_A/B = 0. Optional counters = 0.
- Combinational outputs during reset: GNT_A/B = 0, RAM_WE = 0.
- Arbitration, combinational each cycle:
  - Only A requests: grant A.
  - Only B requests: grant B.
  - Both request: grant the port not equal to LAST.
  - Neither requests: no grant.
- Exactly one of GNT_A/GNT_B is high in any cycle with a request; never both.
- On a granted cycle:
  - RAM_ADDR/RAM_DATA/RAM_WE carry the winner's ADDR/DATA/WE.
  - LAST <= winner at the posedge.
- Idle cycle: RAM_WE = 0, RAM_ADDR = 0, RAM_DATA = 0, LAST unchanged.
- Handshake: a request completes at the posedge where REQ and GNT are both high. The requester may change or drop REQ/ADDR/WE/DATA after that edge. Inputs of an ungranted requester are ignored.
- Read latency: grant on cycle N, then RVALID_x = 1 on cycle N+1 for exactly one cycle. RDATA_x = RAM_Q in that cycle.
- Writes produce no response. RVALID stays 0.
- Back-to-back: a new grant may be issued every cycle. A read granted on N+1 does not disturb the response of cycle N+1, because RAM_Q reflects the address registered at the end of cycle N.
- Read-after-write, same address, consecutive cycles (any ports): the read returns the newly written data.
- Continuous requests from both ports: strict alternation A,B,A,B… No port waits more than one cycle behind the other.
- Reset mid-operation: a pending RVALID is cleared immediately. Any in-flight read response is lost. Requesters must reissue.

Optional Feature:
- RAM_ARB_STATS_EN defined: adds outputs GCNT_A and GCNT_B (8-bit each). Each counts completed grants for its port, reset to 0, wraps 255->0. Also adds input STATS_CLR (synchronous clear, takes precedence over increment).
- RAM_ARB_STATS_EN undefined: those ports and counters do not exist. Behaviour is otherwise identical.

Decomposition:
- Shared package ram_pkg holds:
  - Constants RAM_AW = 6, RAM_DW = 8.
  - Enum port_id_t {PORT_A, PORT_B}, used for LAST and the response-owner register.
- One natural sub-module: rr_arb2, a 2-way round-robin grant with LAST state.
- Everything else (mux, response pipeline, counters) stays in ram_arbiter.

Test Plan:
- Reset, then A writes 0x5A to addr 0x03 → GNT_A same cycle, RAM_WE = 1, RAM_ADDR = 0x03. Next cycle A reads 0x03 → RVALID_A one cycle later, RDATA_A = 0x5A, RVALID_B = 0.
- Both REQ high on first cycle after reset → GNT_A first. With both held for 6 cycles → grant order A,B,A,B,A,B.
- A writes 0x11 to addr 0x3F on cycle N, B reads 0x3F on N+1 → RVALID_B on N+2 with RDATA_B = 0x11 (read-after-write, top-address boundary).
- Pipelined reads A@0x00, B@0x01, A@0x02 on consecutive cycles (memory preloaded 0xA0/0xA1/0xA2) → responses on the following consecutive cycles to the correct ports with the correct data.
- Grant an A read, drop RST_N in the response cycle → RVALID_A falls immediately. After release, the LAST tie goes to A.
- With RAM_ARB_STATS_EN: 300 A grants → GCNT_A = 44 (wrap). STATS_CLR pulse → 0 next cycle, even with a simultaneous grant.

Source files
------------

// File: rtl/ram_pkg.sv
// Shared definitions for the two-port RAM arbiter: RAM geometry and the
// port identifier used for round-robin history and response ownership.
package ram_pkg;

  localparam int RAM_AW = 6;
  localparam int RAM_DW = 8;

  typedef enum logic {
    PORT_A = 1'b0,
    PORT_B = 1'b1
  } port_id_t;

  // The port that should win a tie, given the port that won last.
  function automatic port_id_t other_port(input port_id_t p);
    return (p == PORT_A) ? PORT_B : PORT_A;
  endfunction

endpackage

// File: rtl/ram_arbiter_if.sv
// Bundle of client-side handshake signals (ports A and B) and the RAM-side
// bus. The arbiter uses the slave modport; the environment that models both
// clients and the RAM instance uses the master modport.
interface ram_arbiter_if #(
  parameter int AW = ram_pkg::RAM_AW,
  parameter int DW = ram_pkg::RAM_DW
);

  // client A
  logic          req_a;
  logic          we_a;
  logic [AW-1:0] addr_a;
  logic [DW-1:0] data_a;
  logic          gnt_a;
  logic          rvalid_a;
  logic [DW-1:0] rdata_a;

  // client B
  logic          req_b;
  logic          we_b;
  logic [AW-1:0] addr_b;
  logic [DW-1:0] data_b;
  logic          gnt_b;
  logic          rvalid_b;
  logic [DW-1:0] rdata_b;

  // RAM side
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_data;
  logic          ram_we;
  logic [DW-1:0] ram_q;

  modport slave (
    input  req_a, we_a, addr_a, data_a,
    input  req_b, we_b, addr_b, data_b,
    input  ram_q,
    output gnt_a, rvalid_a, rdata_a,
    output gnt_b, rvalid_b, rdata_b,
    output ram_addr, ram_data, ram_we
  );

  modport master (
    output req_a, we_a, addr_a, data_a,
    output req_b, we_b, addr_b, data_b,
    output ram_q,
    input  gnt_a, rvalid_a, rdata_a,
    input  gnt_b, rvalid_b, rdata_b,
    input  ram_addr, ram_data, ram_we
  );

endinterface

// File: rtl/rr_arb2.sv
// Two-way round-robin grant. The LAST register remembers which port won
// the most recent grant; on a tie the other port wins, so continuous
// requests from both sides alternate strictly. Grants are combinational
// and forced low while reset is asserted.
module rr_arb2
  import ram_pkg::*;
(
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_req_a,
  input  logic i_req_b,
  output logic o_gnt_a,
  output logic o_gnt_b
);

  port_id_t r_last;
  port_id_t w_tie_winner;
  logic     w_gnt_a;
  logic     w_gnt_b;

  assign w_tie_winner = other_port(r_last);

  // Grant decision: single requester always wins, tie goes to the port
  // that did not win last time.
  always_comb begin
    w_gnt_a = 1'b0;
    w_gnt_b = 1'b0;
    if (i_rst_n) begin
      if (i_req_a && i_req_b) begin
        w_gnt_a = (w_tie_winner == PORT_A);
        w_gnt_b = (w_tie_winner == PORT_B);
      end else begin
        w_gnt_a = i_req_a;
        w_gnt_b = i_req_b;
      end
    end
  end

  assign o_gnt_a = w_gnt_a;
  assign o_gnt_b = w_gnt_b;

  // History update: reset makes B the last winner so A takes the first tie;
  // idle cycles leave the history untouched.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_last <= PORT_B;
    end else if (w_gnt_a) begin
      r_last <= PORT_A;
    end else if (w_gnt_b) begin
      r_last <= PORT_B;
    end
  end

endmodule

// File: rtl/ram_arbiter.sv
// Round-robin arbiter and sequencer placing two client masters onto one
// 64x8 single-port synchronous RAM. At most one access is issued per
// cycle; read data (valid the cycle after the address is issued) is routed
// back to whichever port issued the read.
//
// Optional build macro RAM_ARB_STATS_EN adds per-port completed-grant
// counters (o_gcnt_a / o_gcnt_b, wrapping 8-bit) and a synchronous clear
// input i_stats_clr that takes precedence over counting.
module ram_arbiter
  import ram_pkg::*;
#(
  parameter int AW = RAM_AW,
  parameter int DW = RAM_DW
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  ram_arbiter_if.slave  bus
`ifdef RAM_ARB_STATS_EN
  ,
  input  logic          i_stats_clr,
  output logic [7:0]    o_gcnt_a,
  output logic [7:0]    o_gcnt_b
`endif
);

  logic          w_gnt_a;
  logic          w_gnt_b;
  logic [AW-1:0] w_ram_addr;
  logic [DW-1:0] w_ram_data;
  logic          w_ram_we;
  logic          w_rd_issue;
  port_id_t      w_rd_owner;

  logic          r_rsp_valid;
  port_id_t      r_rsp_owner;
  logic          w_rvalid_a;
  logic          w_rvalid_b;

  rr_arb2 u_rr_arb2 (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_req_a (bus.req_a),
    .i_req_b (bus.req_b),
    .o_gnt_a (w_gnt_a),
    .o_gnt_b (w_gnt_b)
  );

  assign bus.gnt_a = w_gnt_a;
  assign bus.gnt_b = w_gnt_b;

  // RAM bus mux: winner's access on a granted cycle, all-zero when idle
  // (grants are already low during reset, so the bus is quiet then too).
  always_comb begin
    w_ram_addr = '0;
    w_ram_data = '0;
    w_ram_we   = 1'b0;
    if (w_gnt_a) begin
      w_ram_addr = bus.addr_a;
      w_ram_data = bus.data_a;
      w_ram_we   = bus.we_a;
    end else if (w_gnt_b) begin
      w_ram_addr = bus.addr_b;
      w_ram_data = bus.data_b;
      w_ram_we   = bus.we_b;
    end
  end

  assign bus.ram_addr = w_ram_addr;
  assign bus.ram_data = w_ram_data;
  assign bus.ram_we   = w_ram_we;

  // A read issued this cycle produces a response next cycle for its owner.
  assign w_rd_issue = (w_gnt_a && !bus.we_a) || (w_gnt_b && !bus.we_b);
  assign w_rd_owner = w_gnt_b ? PORT_B : PORT_A;

  // Response pipeline: one-cycle valid tagged with the issuing port; reset
  // drops any in-flight response.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_rsp_valid <= 1'b0;
      r_rsp_owner <= PORT_A;
    end else begin
      r_rsp_valid <= w_rd_issue;
      if (w_rd_issue) begin
        r_rsp_owner <= w_rd_owner;
      end
    end
  end

  assign w_rvalid_a = r_rsp_valid && (r_rsp_owner == PORT_A);
  assign w_rvalid_b = r_rsp_valid && (r_rsp_owner == PORT_B);

  assign bus.rvalid_a = w_rvalid_a;
  assign bus.rvalid_b = w_rvalid_b;
  assign bus.rdata_a  = w_rvalid_a ? bus.ram_q : '0;
  assign bus.rdata_b  = w_rvalid_b ? bus.ram_q : '0;

`ifdef RAM_ARB_STATS_EN
  logic [7:0] r_gcnt_a;
  logic [7:0] r_gcnt_b;

  // Completed-grant counters; clear wins over a same-cycle grant.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_gcnt_a <= '0;
      r_gcnt_b <= '0;
    end else if (i_stats_clr) begin
      r_gcnt_a <= '0;
      r_gcnt_b <= '0;
    end else begin
      if (w_gnt_a) begin
        r_gcnt_a <= r_gcnt_a + 8'd1;
      end
      if (w_gnt_b) begin
        r_gcnt_b <= r_gcnt_b + 8'd1;
      end
    end
  end

  assign o_gcnt_a = r_gcnt_a;
  assign o_gcnt_b = r_gcnt_b;
`endif

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed testbench for ram_arbiter, including a behavioural model of the
// 64x8 synchronous RAM (write on posedge, registered read address).
`timescale 1ns/1ps
module tb_ram_arbiter;

  logic i_clk;
  logic i_rst_n;
  int   n_pass;
  int   n_total;

  ram_arbiter_if bus ();

`ifdef RAM_ARB_STATS_EN
  logic       stats_clr;
  logic [7:0] gcnt_a;
  logic [7:0] gcnt_b;
`endif

  ram_arbiter dut (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .bus     (bus)
`ifdef RAM_ARB_STATS_EN
    ,
    .i_stats_clr (stats_clr),
    .o_gcnt_a    (gcnt_a),
    .o_gcnt_b    (gcnt_b)
`endif
  );

  // RAM model
  logic [7:0] mem [0:63];
  logic [5:0] r_ram_addr;
  always @(posedge i_clk) begin
    if (bus.ram_we) mem[bus.ram_addr] <= bus.ram_data;
    r_ram_addr <= bus.ram_addr;
  end
  assign bus.ram_q = mem[r_ram_addr];

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.req_a = 1'b0; bus.we_a = 1'b0; bus.addr_a = '0; bus.data_a = '0;
    bus.req_b = 1'b0; bus.we_b = 1'b0; bus.addr_b = '0; bus.data_b = '0;
`ifdef RAM_ARB_STATS_EN
    stats_clr = 1'b0;
`endif
  endtask

  task automatic do_reset();
    idle_inputs();
    i_rst_n = 1'b0;
    step();
    step();
    i_rst_n = 1'b1;
  endtask

  task automatic test_reset();
    idle_inputs();
    i_rst_n = 1'b0;
    step();
    bus.req_a = 1'b1; bus.we_a = 1'b1; bus.addr_a = 6'h05; bus.data_a = 8'hFF;
    bus.req_b = 1'b1;
    #1;
    n_total++;
    if (bus.gnt_a !== 1'b0) $display("FAIL reset_gnt_a: got %b expected 0", bus.gnt_a);
    else n_pass++;
    n_total++;
    if (bus.gnt_b !== 1'b0) $display("FAIL reset_gnt_b: got %b expected 0", bus.gnt_b);
    else n_pass++;
    n_total++;
    if (bus.ram_we !== 1'b0) $display("FAIL reset_ram_we: got %b expected 0", bus.ram_we);
    else n_pass++;
    n_total++;
    if (bus.rvalid_a !== 1'b0 || bus.rvalid_b !== 1'b0)
      $display("FAIL reset_rvalid: got %b%b expected 00", bus.rvalid_a, bus.rvalid_b);
    else n_pass++;
`ifdef RAM_ARB_STATS_EN
    n_total++;
    if (gcnt_a !== 8'd0 || gcnt_b !== 8'd0)
      $display("FAIL reset_gcnt: got %0d/%0d expected 0/0", gcnt_a, gcnt_b);
    else n_pass++;
`endif
    idle_inputs();
    step();
    i_rst_n = 1'b1;
    step();
  endtask

  task automatic test_write_read();
    do_reset();
    bus.req_a = 1'b1; bus.we_a = 1'b1; bus.addr_a = 6'h03; bus.data_a = 8'h5A;
    #1;
    n_total++;
    if (bus.gnt_a !== 1'b1 || bus.gnt_b !== 1'b0)
      $display("FAIL wr_gnt: got a=%b b=%b expected a=1 b=0", bus.gnt_a, bus.gnt_b);
    else n_pass++;
    n_total++;
    if (bus.ram_we !== 1'b1 || bus.ram_addr !== 6'h03 || bus.ram_data !== 8'h5A)
      $display("FAIL wr_ram_bus: got we=%b addr=%0h data=%0h expected we=1 addr=3 data=5a",
               bus.ram_we, bus.ram_addr, bus.ram_data);
    else n_pass++;
    step();
    n_total++;
    if (bus.rvalid_a !== 1'b0) $display("FAIL wr_no_rvalid: got %b expected 0", bus.rvalid_a);
    else n_pass++;
    bus.we_a = 1'b0; bus.data_a = 8'h00;
    #1;
    n_total++;
    if (bus.gnt_a !== 1'b1 || bus.ram_we !== 1'b0 || bus.ram_addr !== 6'h03)
      $display("FAIL rd_issue: got gnt=%b we=%b addr=%0h expected gnt=1 we=0 addr=3",
               bus.gnt_a, bus.ram_we, bus.ram_addr);
    else n_pass++;
    step();
    idle_inputs();
    #1;
    n_total++;
    if (bus.rvalid_a !== 1'b1 || bus.rdata_a !== 8'h5A)
      $display("FAIL rd_resp_a: got v=%b d=%0h expected v=1 d=5a", bus.rvalid_a, bus.rdata_a);
    else n_pass++;
    n_total++;
    if (bus.rvalid_b !== 1'b0 || bus.rdata_b !== 8'h00)
      $display("FAIL rd_resp_b_quiet: got v=%b d=%0h expected v=0 d=0", bus.rvalid_b, bus.rdata_b);
    else n_pass++;
    n_total++;
    if (bus.ram_we !== 1'b0 || bus.ram_addr !== 6'h00 || bus.ram_data !== 8'h00)
      $display("FAIL idle_bus: got we=%b addr=%0h data=%0h expected all 0",
               bus.ram_we, bus.ram_addr, bus.ram_data);
    else n_pass++;
    step();
    n_total++;
    if (bus.rvalid_a !== 1'b0 || bus.rdata_a !== 8'h00)
      $display("FAIL rd_one_cycle: got v=%b d=%0h expected v=0 d=0", bus.rvalid_a, bus.rdata_a);
    else n_pass++;
  endtask

  task automatic test_alternation();
    do_reset();
    bus.req_a = 1'b1; bus.addr_a = 6'h03;
    bus.req_b = 1'b1; bus.addr_b = 6'h04;
    for (int i = 0; i < 6; i++) begin
      #1;
      n_total++;
      if (bus.gnt_a !== (i % 2 == 0) || bus.gnt_b !== (i % 2 == 1))
        $display("FAIL alt_gnt[%0d]: got a=%b b=%b expected a=%0d b=%0d",
                 i, bus.gnt_a, bus.gnt_b, (i % 2 == 0), (i % 2 == 1));
      else n_pass++;
      n_total++;
      if (bus.ram_addr !== ((i % 2 == 0) ? 6'h03 : 6'h04))
        $display("FAIL alt_addr[%0d]: got %0h expected %0h",
                 i, bus.ram_addr, (i % 2 == 0) ? 6'h03 : 6'h04);
      else n_pass++;
      if (i > 0) begin
        n_total++;
        if (bus.rvalid_a !== (i % 2 == 1) || bus.rvalid_b !== (i % 2 == 0))
          $display("FAIL alt_rvalid[%0d]: got a=%b b=%b expected a=%0d b=%0d",
                   i, bus.rvalid_a, bus.rvalid_b, (i % 2 == 1), (i % 2 == 0));
        else n_pass++;
      end
      step();
    end
    idle_inputs();
    #1;
    n_total++;
    if (bus.rvalid_b !== 1'b1 || bus.rvalid_a !== 1'b0)
      $display("FAIL alt_last_rsp: got a=%b b=%b expected a=0 b=1", bus.rvalid_a, bus.rvalid_b);
    else n_pass++;
    step();
  endtask

  task automatic test_raw_top();
    bus.req_a = 1'b1; bus.we_a = 1'b1; bus.addr_a = 6'h3F; bus.data_a = 8'h11;
    #1;
    n_total++;
    if (bus.gnt_a !== 1'b1 || bus.ram_addr !== 6'h3F)
      $display("FAIL raw_wr: got gnt=%b addr=%0h expected gnt=1 addr=3f", bus.gnt_a, bus.ram_addr);
    else n_pass++;
    step();
    idle_inputs();
    bus.req_b = 1'b1; bus.we_b = 1'b0; bus.addr_b = 6'h3F;
    #1;
    n_total++;
    if (bus.gnt_b !== 1'b1 || bus.gnt_a !== 1'b0 || bus.ram_addr !== 6'h3F)
      $display("FAIL raw_rd: got gnt_b=%b gnt_a=%b addr=%0h expected 1 0 3f",
               bus.gnt_b, bus.gnt_a, bus.ram_addr);
    else n_pass++;
    step();
    idle_inputs();
    #1;
    n_total++;
    if (bus.rvalid_b !== 1'b1 || bus.rdata_b !== 8'h11)
      $display("FAIL raw_resp: got v=%b d=%0h expected v=1 d=11", bus.rvalid_b, bus.rdata_b);
    else n_pass++;
    n_total++;
    if (bus.rvalid_a !== 1'b0 || bus.rdata_a !== 8'h00)
      $display("FAIL raw_a_quiet: got v=%b d=%0h expected v=0 d=0", bus.rvalid_a, bus.rdata_a);
    else n_pass++;
    step();
  endtask

  task automatic test_back_to_back();
    // preload 0xA0/0xA1/0xA2 at 0..2 through port A
    for (int i = 0; i < 3; i++) begin
      bus.req_a = 1'b1; bus.we_a = 1'b1; bus.addr_a = 6'(i); bus.data_a = 8'hA0 + 8'(i);
      step();
    end
    idle_inputs();
    bus.req_a = 1'b1; bus.addr_a = 6'h00;
    step();
    idle_inputs();
    bus.req_b = 1'b1; bus.addr_b = 6'h01;
    #1;
    n_total++;
    if (bus.rvalid_a !== 1'b1 || bus.rdata_a !== 8'hA0 || bus.rvalid_b !== 1'b0)
      $display("FAIL b2b_rsp0: got va=%b da=%0h vb=%b expected 1 a0 0",
               bus.rvalid_a, bus.rdata_a, bus.rvalid_b);
    else n_pass++;
    step();
    idle_inputs();
    bus.req_a = 1'b1; bus.addr_a = 6'h02;
    #1;
    n_total++;
    if (bus.rvalid_b !== 1'b1 || bus.rdata_b !== 8'hA1 || bus.rvalid_a !== 1'b0)
      $display("FAIL b2b_rsp1: got vb=%b db=%0h va=%b expected 1 a1 0",
               bus.rvalid_b, bus.rdata_b, bus.rvalid_a);
    else n_pass++;
    step();
    idle_inputs();
    #1;
    n_total++;
    if (bus.rvalid_a !== 1'b1 || bus.rdata_a !== 8'hA2 || bus.rvalid_b !== 1'b0)
      $display("FAIL b2b_rsp2: got va=%b da=%0h vb=%b expected 1 a2 0",
               bus.rvalid_a, bus.rdata_a, bus.rvalid_b);
    else n_pass++;
    step();
  endtask

  task automatic test_reset_mid();
    bus.req_a = 1'b1; bus.we_a = 1'b0; bus.addr_a = 6'h03;
    step();
    idle_inputs();
    #1;
    n_total++;
    if (bus.rvalid_a !== 1'b1)
      $display("FAIL midrst_pre: got %b expected 1", bus.rvalid_a);
    else n_pass++;
    i_rst_n = 1'b0;
    #1;
    n_total++;
    if (bus.rvalid_a !== 1'b0 || bus.rdata_a !== 8'h00)
      $display("FAIL midrst_drop: got v=%b d=%0h expected v=0 d=0", bus.rvalid_a, bus.rdata_a);
    else n_pass++;
    step();
    i_rst_n = 1'b1;
    bus.req_a = 1'b1; bus.addr_a = 6'h03;
    bus.req_b = 1'b1; bus.addr_b = 6'h04;
    #1;
    n_total++;
    if (bus.gnt_a !== 1'b1 || bus.gnt_b !== 1'b0)
      $display("FAIL midrst_tie: got a=%b b=%b expected a=1 b=0", bus.gnt_a, bus.gnt_b);
    else n_pass++;
    step();
    idle_inputs();
    step();
  endtask

`ifdef RAM_ARB_STATS_EN
  task automatic test_stats();
    do_reset();
    bus.req_a = 1'b1; bus.we_a = 1'b1; bus.addr_a = 6'h10; bus.data_a = 8'h00;
    repeat (300) step();
    idle_inputs();
    #1;
    n_total++;
    if (gcnt_a !== 8'd44 || gcnt_b !== 8'd0)
      $display("FAIL stats_wrap: got a=%0d b=%0d expected a=44 b=0", gcnt_a, gcnt_b);
    else n_pass++;
    bus.req_a = 1'b1; bus.we_a = 1'b1; bus.addr_a = 6'h10;
    stats_clr = 1'b1;
    step();
    idle_inputs();
    #1;
    n_total++;
    if (gcnt_a !== 8'd0)
      $display("FAIL stats_clr: got %0d expected 0", gcnt_a);
    else n_pass++;
    bus.req_b = 1'b1; bus.we_b = 1'b1; bus.addr_b = 6'h11;
    step();
    idle_inputs();
    #1;
    n_total++;
    if (gcnt_b !== 8'd1 || gcnt_a !== 8'd0)
      $display("FAIL stats_b_count: got a=%0d b=%0d expected a=0 b=1", gcnt_a, gcnt_b);
    else n_pass++;
  endtask
`endif

  initial begin
    n_pass  = 0;
    n_total = 0;
    i_rst_n = 1'b0;
    idle_inputs();
    test_reset();
    test_write_read();
    test_alternation();
    test_raw_top();
    test_back_to_back();
    test_reset_mid();
`ifdef RAM_ARB_STATS_EN
    test_stats();
`endif
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
